// File: rtl/hog_axil_master.sv
// hog_axil_master: turns single cmd requests into AXI-Lite transactions.
// The optional error counter is enabled by defining HOG_AXIL_MASTER_ERRCNT_EN.
// Latency: accept->AW/W/AR valid 1 cycle; slave response->rsp_valid 1 cycle.
// Backpressure: one transaction in flight; cmd_ready only in IDLE; rsp held until rsp_ready.
module hog_axil_master #(
   parameter int AXIL_AW = 7,
   parameter int AXIL_DW = 32
) (
   input  logic                 aclk,
   input  logic                 arest,
   // command side
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_we,
   input  logic [AXIL_AW-1:0]   cmd_addr,
   input  logic [AXIL_DW-1:0]   cmd_wdata,
   input  logic [3:0]           cmd_wstrb,
   // response side
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [AXIL_DW-1:0]   rsp_rdata,
   output logic [1:0]           rsp_resp,
   // AXI-Lite write address channel
   output logic [AXIL_AW-1:0]   m_axil_awaddr,
   output logic [2:0]           m_axil_awprot,
   output logic                 m_axil_awvalid,
   input  logic                 m_axil_awready,
   // AXI-Lite write data channel
   output logic [AXIL_DW-1:0]   m_axil_wdata,
   output logic [AXIL_DW/8-1:0] m_axil_wstrb,
   output logic                 m_axil_wvalid,
   input  logic                 m_axil_wready,
   // AXI-Lite write response channel
   input  logic [1:0]           m_axil_bresp,
   input  logic                 m_axil_bvalid,
   output logic                 m_axil_bready,
   // AXI-Lite read address channel
   output logic [AXIL_AW-1:0]   m_axil_araddr,
   output logic [2:0]           m_axil_arprot,
   output logic                 m_axil_arvalid,
   input  logic                 m_axil_arready,
   // AXI-Lite read data channel
   input  logic [AXIL_DW-1:0]   m_axil_rdata,
   input  logic [1:0]           m_axil_rresp,
   input  logic                 m_axil_rvalid,
   output logic                 m_axil_rready
`ifdef HOG_AXIL_MASTER_ERRCNT_EN
   ,
   output logic [15:0]          err_cnt
`endif
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      WR_RESP = 3'd2,
      RD_ADDR = 3'd3,
      RD_DATA = 3'd4,
      RSP     = 3'd5
   } state_t;

   state_t                 state_q, state_d;

   // latched command and response
   logic [AXIL_AW-1:0]     addr_q;
   logic [AXIL_DW-1:0]     wdata_q;
   logic [AXIL_DW/8-1:0]   wstrb_q;
   logic [AXIL_DW-1:0]     rdata_q;
   logic [1:0]             resp_q;

   // per-channel pending flags for the two write request channels
   logic                   aw_pend_q;
   logic                   w_pend_q;

   // handshake strobes
   logic                   cmd_fire;
   logic                   aw_fire;
   logic                   w_fire;
   logic                   b_fire;
   logic                   r_fire;

   assign cmd_fire = cmd_valid && cmd_ready;
   assign aw_fire  = m_axil_awvalid && m_axil_awready;
   assign w_fire   = m_axil_wvalid && m_axil_wready;
   assign b_fire   = m_axil_bvalid && m_axil_bready;
   assign r_fire   = m_axil_rvalid && m_axil_rready;

   // request-side outputs come straight from registers so they stay stable under backpressure
   assign m_axil_awaddr  = addr_q;
   assign m_axil_araddr  = addr_q;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = wstrb_q;
   assign m_axil_awvalid = aw_pend_q;
   assign m_axil_wvalid  = w_pend_q;
   assign rsp_rdata      = rdata_q;
   assign rsp_resp       = resp_q;

   // state register
   always_ff @(posedge aclk) begin
      if (arest) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state and per-state handshake outputs
   always_comb begin
      state_d        = state_q;
      cmd_ready      = 1'b0;
      m_axil_arvalid = 1'b0;
      m_axil_bready  = 1'b0;
      m_axil_rready  = 1'b0;
      rsp_valid      = 1'b0;
      case (state_q)
         IDLE: begin
            // held low while reset is applied so no command slips in during reset
            cmd_ready = !arest;
            if (cmd_valid && !arest) begin
               state_d = cmd_we ? WR : RD_ADDR;
            end
         end
         WR: begin
            // AW and W complete independently; leave once neither is outstanding
            if ((!aw_pend_q || aw_fire) && (!w_pend_q || w_fire)) begin
               state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            m_axil_bready = 1'b1;
            if (m_axil_bvalid) begin
               state_d = RSP;
            end
         end
         RD_ADDR: begin
            m_axil_arvalid = 1'b1;
            if (m_axil_arready) begin
               state_d = RD_DATA;
            end
         end
         RD_DATA: begin
            m_axil_rready = 1'b1;
            if (m_axil_rvalid) begin
               state_d = RSP;
            end
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // command latch, write-channel pending flags and response capture
   always_ff @(posedge aclk) begin
      if (arest) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= '0;
         aw_pend_q <= 1'b0;
         w_pend_q  <= 1'b0;
      end else begin
         if (cmd_fire) begin
            // word-align: the two byte-offset bits are always cleared
            addr_q    <= cmd_addr & ~AXIL_AW'(3);
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            aw_pend_q <= cmd_we;
            w_pend_q  <= cmd_we;
         end
         if (aw_fire) begin
            aw_pend_q <= 1'b0;
         end
         if (w_fire) begin
            w_pend_q <= 1'b0;
         end
         if (b_fire) begin
            rdata_q <= '0;
            resp_q  <= m_axil_bresp;
         end
         if (r_fire) begin
            rdata_q <= m_axil_rdata;
            resp_q  <= m_axil_rresp;
         end
      end
   end

`ifdef HOG_AXIL_MASTER_ERRCNT_EN
   logic       rsp_capt;
   logic [1:0] rsp_capt_resp;

   assign rsp_capt      = b_fire || r_fire;
   assign rsp_capt_resp = b_fire ? m_axil_bresp : m_axil_rresp;

   // saturating count of non-OKAY responses taken from the slave
   always_ff @(posedge aclk) begin
      if (arest) begin
         err_cnt <= '0;
      end else if (rsp_capt && (rsp_capt_resp != 2'b00) && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hog_axil_master.sv
// Bench for hog_axil_master: configurable-latency AXI-Lite slave plus a word-array reference model.
// Directed cases for the alignment, hold, stray-response and reset behaviour, then random traffic.
// Define HOG_AXIL_MASTER_ERRCNT_EN to also check the error counter.
`timescale 1ns/1ps
module tb_hog_axil_master;
   localparam int AW = 7;
   localparam int DW = 32;

   logic          aclk;
   logic          arest;
   logic          cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
   logic [2:0]    m_axil_awprot, m_axil_arprot;
   logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
   logic [DW-1:0] m_axil_wdata, m_axil_rdata;
   logic [3:0]    m_axil_wstrb;
   logic [1:0]    m_axil_bresp, m_axil_rresp;
   logic          m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
   logic          m_axil_rvalid, m_axil_rready;
`ifdef HOG_AXIL_MASTER_ERRCNT_EN
   logic [15:0]   err_cnt;
`endif

   hog_axil_master #(.AXIL_AW(AW), .AXIL_DW(DW)) dut (
      .aclk(aclk), .arest(arest),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
      .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
      .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
      .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
      .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
      .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
      .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
      .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
      .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
`ifdef HOG_AXIL_MASTER_ERRCNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- slave model ----------------
   int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0] resp_sel = 2'b00;
   logic       stray = 1'b0;
   int         aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   logic       aw_got, w_got, b_pend, r_pend;
   logic [AW-1:0] s_awaddr, s_araddr;
   logic [31:0]   s_wdata;
   logic [3:0]    s_wstrb;
   logic [31:0]   s_mem [32];
   int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;

   initial begin
      for (int i = 0; i < 32; i++) s_mem[i] = '0;
      s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
   end

   assign m_axil_awready = m_axil_awvalid && (aw_cnt >= aw_dly);
   assign m_axil_wready  = m_axil_wvalid && (w_cnt >= w_dly);
   assign m_axil_arready = m_axil_arvalid && (ar_cnt >= ar_dly);
   assign m_axil_bvalid  = (b_pend && (b_cnt >= b_dly)) || stray;
   assign m_axil_rvalid  = (r_pend && (r_cnt >= r_dly)) || stray;
   assign m_axil_bresp   = resp_sel;
   assign m_axil_rresp   = resp_sel;
   assign m_axil_rdata   = s_mem[s_araddr[6:2]];

   always @(posedge aclk) begin
      if (arest) begin
         aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
         aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
      end else begin
         if (m_axil_awvalid) aw_cnt <= m_axil_awready ? 0 : aw_cnt + 1;
         if (m_axil_wvalid)  w_cnt  <= m_axil_wready  ? 0 : w_cnt + 1;
         if (m_axil_arvalid) ar_cnt <= m_axil_arready ? 0 : ar_cnt + 1;
         if (m_axil_awvalid && m_axil_awready) begin
            aw_got <= 1; s_awaddr <= m_axil_awaddr; n_aw <= n_aw + 1;
         end
         if (m_axil_wvalid && m_axil_wready) begin
            w_got <= 1; s_wdata <= m_axil_wdata; s_wstrb <= m_axil_wstrb; n_w <= n_w + 1;
         end
         if (aw_got && w_got) begin
            for (int b = 0; b < 4; b++)
               if (s_wstrb[b]) s_mem[s_awaddr[6:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            aw_got <= 0; w_got <= 0; b_pend <= 1; b_cnt <= 0;
         end else if (b_pend) begin
            if (m_axil_bvalid && m_axil_bready) begin
               b_pend <= 0; n_b <= n_b + 1;
            end else if (!m_axil_bvalid) b_cnt <= b_cnt + 1;
         end
         if (m_axil_arvalid && m_axil_arready) begin
            r_pend <= 1; r_cnt <= 0; s_araddr <= m_axil_araddr; n_ar <= n_ar + 1;
         end else if (r_pend) begin
            if (m_axil_rvalid && m_axil_rready) begin
               r_pend <= 0; n_r <= n_r + 1;
            end else if (!m_axil_rvalid) r_cnt <= r_cnt + 1;
         end
      end
   end

   // ---------------- protocol monitor ----------------
   int aw_hi = 0, w_hi = 0;
   logic p_aw, p_w, p_ar, p_rsp;
   logic [AW-1:0] q_awaddr, q_araddr;
   logic [31:0]   q_wdata, q_rdata;
   logic [3:0]    q_wstrb;
   logic [1:0]    q_resp;

   always @(negedge aclk) begin
      if (arest) begin
         p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
      end else begin
         if (m_axil_awvalid) chk("awprot", {29'd0, m_axil_awprot}, 32'd0);
         if (m_axil_arvalid) chk("arprot", {29'd0, m_axil_arprot}, 32'd0);
         if (p_aw) begin
            chk("awvalid_held", m_axil_awvalid, 1);
            chk("awaddr_stable", m_axil_awaddr, q_awaddr);
         end
         if (p_w) begin
            chk("wvalid_held", m_axil_wvalid, 1);
            chk("wdata_stable", m_axil_wdata, q_wdata);
            chk("wstrb_stable", m_axil_wstrb, q_wstrb);
         end
         if (p_ar) begin
            chk("arvalid_held", m_axil_arvalid, 1);
            chk("araddr_stable", m_axil_araddr, q_araddr);
         end
         if (p_rsp) begin
            chk("rsp_valid_held", rsp_valid, 1);
            chk("rsp_rdata_stable", rsp_rdata, q_rdata);
            chk("rsp_resp_stable", rsp_resp, q_resp);
         end
         if (m_axil_awvalid) aw_hi++;
         if (m_axil_wvalid)  w_hi++;
         p_aw = m_axil_awvalid && !m_axil_awready;
         p_w  = m_axil_wvalid && !m_axil_wready;
         p_ar = m_axil_arvalid && !m_axil_arready;
         p_rsp = rsp_valid && !rsp_ready;
         q_awaddr = m_axil_awaddr; q_araddr = m_axil_araddr;
         q_wdata = m_axil_wdata; q_wstrb = m_axil_wstrb;
         q_rdata = rsp_rdata; q_resp = rsp_resp;
      end
   end

   // ---------------- reference model ----------------
   logic [31:0] model_mem [32];
   int          err_model = 0;

   task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) model_mem[a[6:2]][8*b +: 8] = d[8*b +: 8];
   endtask

   // ---------------- driver ----------------
   task automatic start_cmd(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      int t;
      cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 200) begin @(negedge aclk); t++; end
      chk("cmd_accept_timeout", t < 200, 1);
      @(negedge aclk);
      cmd_valid = 1'b0;
      chk("awvalid_latency", m_axil_awvalid, we);
      chk("wvalid_latency", m_axil_wvalid, we);
      chk("arvalid_latency", m_axil_arvalid, !we);
   endtask

   task automatic do_cmd(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] rs,
                         input int awd, input int wd, input int bd, input int ard, input int rd,
                         input int hold);
      int t, aw0, w0, b0, ar0, r0, awh0, wh0;
      logic [31:0] exp_d;
      logic [AW-1:0] aligned;
      aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd; resp_sel = rs;
      aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r; awh0 = aw_hi; wh0 = w_hi;
      aligned = a & 7'h7C;
      if (we) begin
         model_write(a, d, s);
         exp_d = 32'd0;
      end else begin
         exp_d = model_mem[a[6:2]];
      end
      if (rs != 2'b00 && err_model < 65535) err_model++;
      start_cmd(we, a, d, s);
      t = 0;
      while (!rsp_valid && t < 300) begin @(negedge aclk); t++; end
      chk("rsp_timeout", t < 300, 1);
      chk("rsp_rdata", rsp_rdata, exp_d);
      chk("rsp_resp", rsp_resp, rs);
      for (int i = 0; i < hold; i++) begin
         chk("cmd_ready_during_rsp", cmd_ready, 0);
         @(negedge aclk);
         chk("rsp_valid_hold", rsp_valid, 1);
         chk("rsp_rdata_hold", rsp_rdata, exp_d);
      end
      rsp_ready = 1'b1;
      @(negedge aclk);
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", rsp_valid, 0);
      chk("cmd_ready_back", cmd_ready, 1);
      if (we) begin
         chk("aw_handshakes", n_aw - aw0, 1);
         chk("w_handshakes", n_w - w0, 1);
         chk("b_handshakes", n_b - b0, 1);
         chk("awaddr_seen", s_awaddr, aligned);
         chk("wdata_seen", s_wdata, d);
         chk("wstrb_seen", s_wstrb, s);
         chk("awvalid_cycles", aw_hi - awh0, awd + 1);
         chk("wvalid_cycles", w_hi - wh0, wd + 1);
      end else begin
         chk("ar_handshakes", n_ar - ar0, 1);
         chk("r_handshakes", n_r - r0, 1);
         chk("araddr_seen", s_araddr, aligned);
         chk("no_write_on_read", n_aw - aw0, 0);
      end
`ifdef HOG_AXIL_MASTER_ERRCNT_EN
      chk("err_cnt", err_cnt, err_model);
`endif
   endtask

   task automatic check_idle_outputs(input string ctx);
      chk({ctx, "_cmd_ready"}, cmd_ready, 0);
      chk({ctx, "_rsp_valid"}, rsp_valid, 0);
      chk({ctx, "_awvalid"}, m_axil_awvalid, 0);
      chk({ctx, "_wvalid"}, m_axil_wvalid, 0);
      chk({ctx, "_arvalid"}, m_axil_arvalid, 0);
      chk({ctx, "_bready"}, m_axil_bready, 0);
      chk({ctx, "_rready"}, m_axil_rready, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      arest = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;

      // reset state
      repeat (3) @(negedge aclk);
      check_idle_outputs("reset");
      chk("reset_rsp_rdata", rsp_rdata, 0);
      chk("reset_rsp_resp", rsp_resp, 0);
`ifdef HOG_AXIL_MASTER_ERRCNT_EN
      chk("reset_err_cnt", err_cnt, 0);
`endif
      arest = 1'b0;
      #1;
      chk("cmd_ready_after_reset", cmd_ready, 1);

      // write, AW and W accepted together
      do_cmd(1, 7'h3C, 32'h1, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0);
      // wready three cycles ahead of awready
      do_cmd(1, 7'h3C, 32'hA5A5_0001, 4'hF, 2'b00, 3, 0, 1, 0, 0, 0);
      // awready ahead of wready
      do_cmd(1, 7'h38, 32'h1234_5678, 4'h5, 2'b00, 0, 2, 0, 0, 0, 1);
      // read with data two cycles after arready
      do_cmd(1, 7'h40, 32'h0020_0010, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0);
      do_cmd(0, 7'h40, 32'h0, 4'h0, 2'b00, 0, 0, 0, 1, 2, 0);
      // misaligned address, response held off five cycles
      do_cmd(1, 7'h43, 32'hCAFE_F00D, 4'hC, 2'b00, 1, 1, 2, 0, 0, 5);
      do_cmd(0, 7'h43, 32'h0, 4'h0, 2'b00, 0, 0, 0, 2, 1, 5);
      // non-OKAY responses pass straight through
      do_cmd(1, 7'h08, 32'h0BAD_0BAD, 4'hF, 2'b10, 0, 0, 0, 0, 0, 0);
      do_cmd(0, 7'h08, 32'h0, 4'h0, 2'b11, 0, 0, 0, 0, 0, 1);

      // stray B/R valids while idle are ignored
      stray = 1'b1; resp_sel = 2'b10;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         chk("stray_bready", m_axil_bready, 0);
         chk("stray_rready", m_axil_rready, 0);
         chk("stray_rsp_valid", rsp_valid, 0);
         chk("stray_cmd_ready", cmd_ready, 1);
      end
      stray = 1'b0;
`ifdef HOG_AXIL_MASTER_ERRCNT_EN
      chk("stray_err_cnt", err_cnt, err_model);

      // three SLVERR reads then reset clears the count
      arest = 1'b1; @(negedge aclk); arest = 1'b0; err_model = 0;
      for (int i = 0; i < 3; i++) do_cmd(0, 7'h10, 32'h0, 4'h0, 2'b10, 0, 0, 0, 0, 0, 0);
      chk("err_cnt_three", err_cnt, 3);
      arest = 1'b1; @(negedge aclk);
      chk("err_cnt_reset", err_cnt, 0);
      arest = 1'b0; err_model = 0;
      #1;
`endif

      // reset while waiting for the write response abandons it
      aw_dly = 0; w_dly = 0; b_dly = 8; resp_sel = 2'b00;
      start_cmd(1, 7'h14, 32'hDEAD_BEEF, 4'hF);
      t = 0;
      while (!m_axil_bready && t < 50) begin @(negedge aclk); t++; end
      chk("wr_resp_reached", m_axil_bready, 1);
      repeat (2) @(negedge aclk);
      model_write(7'h14, 32'hDEAD_BEEF, 4'hF);
      arest = 1'b1;
      @(negedge aclk);
      check_idle_outputs("midreset");
      arest = 1'b0;
      err_model = 0;
      #1;
      chk("cmd_ready_after_midreset", cmd_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         chk("no_rsp_after_abandon", rsp_valid, 0);
      end
      do_cmd(0, 7'h14, 32'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);

      // random traffic
      for (int n = 0; n < 60; n++) begin
         logic          we;
         logic [AW-1:0] a;
         logic [31:0]   d;
         logic [3:0]    s;
         logic [1:0]    rs;
         we = 1'($urandom_range(0, 1));
         a  = AW'($urandom_range(0, 127));
         d  = $urandom;
         s  = 4'($urandom_range(0, 15));
         rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         do_cmd(we, a, d, s, rs, $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
